// File: rtl/lvds_8b10b_transmit_if.sv
// Parallel payload handshake into the LVDS 8b10b transmitter.
// The source drives data_i/data_valid_i; the transmitter answers with ready_o.
interface lvds_8b10b_transmit_if #(
   parameter int NUM_BYTES = 2
);
   logic [8*NUM_BYTES-1:0] data_i;
   logic                   data_valid_i;
   logic                   ready_o;

   modport master (output data_i, output data_valid_i, input ready_o);
   modport slave  (input data_i, input data_valid_i, output ready_o);
endinterface

// File: rtl/lvds_8b10b_transmit.sv
// Serial 8b10b frame transmitter: K28.1 comma followed by NUM_BYTES data symbols, LSB byte first.
// Define LVDS_TX_IDLE_FILL_EN to send D21.5 between frames instead of a quiet (all-zero) line.

// Combinational 8b10b encoder. datain[8] is the K flag; dataout[0] is bit 'a' (first on the wire).
module encode8b10b (
   input  logic [8:0] datain,
   input  logic       dispin,
   output logic [9:0] dataout,
   output logic       dispout
);
   logic [4:0] w_x;
   logic [2:0] w_y;
   logic       w_k;
   logic       w_rd6;
   logic       w_alt7;
   logic [5:0] w_6n;
   logic [5:0] w_6;
   logic [3:0] w_4n;
   logic [3:0] w_4;
   logic [9:0] w_str;

   assign w_k = datain[8];
   assign w_y = datain[7:5];
   assign w_x = datain[4:0];

   // 5b/6b sub-block in its RD- form, written abcdei with 'a' in bit 5
   always_comb begin
      w_6n = 6'b000000;
      case (w_x)
         5'd0:  w_6n = 6'b100111;
         5'd1:  w_6n = 6'b011101;
         5'd2:  w_6n = 6'b101101;
         5'd3:  w_6n = 6'b110001;
         5'd4:  w_6n = 6'b110101;
         5'd5:  w_6n = 6'b101001;
         5'd6:  w_6n = 6'b011001;
         5'd7:  w_6n = 6'b111000;
         5'd8:  w_6n = 6'b111001;
         5'd9:  w_6n = 6'b100101;
         5'd10: w_6n = 6'b010101;
         5'd11: w_6n = 6'b110100;
         5'd12: w_6n = 6'b001101;
         5'd13: w_6n = 6'b101100;
         5'd14: w_6n = 6'b011100;
         5'd15: w_6n = 6'b010111;
         5'd16: w_6n = 6'b011011;
         5'd17: w_6n = 6'b100011;
         5'd18: w_6n = 6'b010011;
         5'd19: w_6n = 6'b110010;
         5'd20: w_6n = 6'b001011;
         5'd21: w_6n = 6'b101010;
         5'd22: w_6n = 6'b011010;
         5'd23: w_6n = 6'b111010;
         5'd24: w_6n = 6'b110011;
         5'd25: w_6n = 6'b100110;
         5'd26: w_6n = 6'b010110;
         5'd27: w_6n = 6'b110110;
         5'd28: w_6n = w_k ? 6'b001111 : 6'b001110;
         5'd29: w_6n = 6'b101110;
         5'd30: w_6n = 6'b011110;
         5'd31: w_6n = 6'b101011;
         default: w_6n = 6'b000000;
      endcase
   end

   always_comb begin
      w_6    = (dispin && (($countones(w_6n) != 3) || (w_x == 5'd7))) ? ~w_6n : w_6n;
      w_rd6  = dispin ^ ($countones(w_6n) != 3);
      // A7 avoids a run of five equal bits across the sub-block boundary
      w_alt7 = w_k
            || (!w_rd6 && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20)))
            || ( w_rd6 && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)));
      case (w_y)
         3'd0:    w_4n = 4'b1011;
         3'd1:    w_4n = 4'b1001;
         3'd2:    w_4n = 4'b0101;
         3'd3:    w_4n = 4'b1100;
         3'd4:    w_4n = 4'b1101;
         3'd5:    w_4n = 4'b1010;
         3'd6:    w_4n = 4'b0110;
         default: w_4n = w_alt7 ? 4'b0111 : 4'b1110;
      endcase
      if (w_k && ((w_y == 3'd1) || (w_y == 3'd2) || (w_y == 3'd5) || (w_y == 3'd6)))
         w_4 = w_rd6 ? w_4n : ~w_4n;
      else
         w_4 = (w_rd6 && (($countones(w_4n) != 2) || (w_y == 3'd3))) ? ~w_4n : w_4n;
      dispout = w_rd6 ^ ($countones(w_4n) != 2);
      w_str   = {w_6, w_4};
      for (int i = 0; i < 10; i++) dataout[i] = w_str[9-i];
   end
endmodule

// state  | meaning
// S_IDLE | no frame on the wire; a pending word starts with a comma at the next boundary
// S_DATA | comma sent; one data byte loaded per boundary until the last
module lvds_8b10b_transmit #(
   parameter int         NUM_BYTES  = 2,
   parameter logic [8:0] COMMA_CODE = 9'b100111100,
   parameter logic [8:0] IDLE_CODE  = 9'b010110101
) (
   input  logic                 clk,
   input  logic                 reset,
   lvds_8b10b_transmit_if.slave bus,
   output logic                 serial_o,
   output logic                 busy_o,
   output logic                 frame_sent_o
);
   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   typedef enum logic {S_IDLE, S_DATA} state_t;

   state_t                 r_state, w_state_nxt;
   logic [3:0]             r_bit_cnt;
   logic [9:0]             r_shift;
   logic                   r_rd;
   logic                   r_pending;
   logic                   r_busy, w_busy_nxt;
   logic                   r_frame_sent;
   logic [8*NUM_BYTES-1:0] r_hold;
   logic [IDX_W-1:0]       r_byte_idx, w_byte_idx_nxt;
   logic                   w_boundary, w_handshake, w_last;
   logic                   w_use_enc, w_clear, w_pulse;
   logic [8:0]             w_sym;
   logic [9:0]             w_code;
   logic                   w_dispout;

   assign w_boundary   = (r_bit_cnt == 4'd9);
   assign w_handshake  = bus.data_valid_i & ~r_pending;
   assign w_last       = (r_byte_idx == IDX_W'(NUM_BYTES - 1));
   assign bus.ready_o  = ~r_pending;
   assign serial_o     = r_shift[0];
   assign busy_o       = r_busy;
   assign frame_sent_o = r_frame_sent;

   encode8b10b u_enc (
      .datain  (w_sym),
      .dispin  (r_rd),
      .dataout (w_code),
      .dispout (w_dispout)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_byte_idx_nxt = r_byte_idx;
      w_sym          = IDLE_CODE;
      w_use_enc      = 1'b0;
      w_clear        = 1'b0;
      w_pulse        = 1'b0;
      w_busy_nxt     = r_busy;
      if (w_boundary) begin
         case (r_state)
            S_IDLE: begin
               w_busy_nxt = r_pending;
               if (r_pending) begin
                  w_sym          = COMMA_CODE;
                  w_use_enc      = 1'b1;
                  w_state_nxt    = S_DATA;
                  w_byte_idx_nxt = '0;
               end else begin
`ifdef LVDS_TX_IDLE_FILL_EN
                  w_use_enc = 1'b1;
`else
                  w_use_enc = 1'b0;
`endif
               end
            end
            S_DATA: begin
               w_sym      = {1'b0, r_hold[{r_byte_idx, 3'b000} +: 8]};
               w_use_enc  = 1'b1;
               w_busy_nxt = 1'b1;
               if (w_last) begin
                  w_clear        = 1'b1;
                  w_pulse        = 1'b1;
                  w_state_nxt    = S_IDLE;
                  w_byte_idx_nxt = '0;
               end else begin
                  w_byte_idx_nxt = r_byte_idx + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_byte_idx   <= '0;
         r_bit_cnt    <= 4'd0;
         r_shift      <= 10'd0;
         r_rd         <= 1'b0;
         r_pending    <= 1'b0;
         r_hold       <= '0;
         r_busy       <= 1'b0;
         r_frame_sent <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_byte_idx   <= w_byte_idx_nxt;
         r_bit_cnt    <= w_boundary ? 4'd0 : r_bit_cnt + 4'd1;
         r_busy       <= w_busy_nxt;
         r_frame_sent <= w_pulse;
         if (w_boundary) begin
            if (w_use_enc) begin
               r_shift <= w_code;
               r_rd    <= w_dispout;
            end else begin
               r_shift <= 10'd0;
            end
         end else begin
            r_shift <= {1'b0, r_shift[9:1]};
         end
         // pending can only be set while empty and only cleared while full, so the two never collide
         if (w_handshake) begin
            r_hold    <= bus.data_i;
            r_pending <= 1'b1;
         end else if (w_clear) begin
            r_pending <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_lvds_8b10b_transmit.sv
// Randomized bench for lvds_8b10b_transmit against a symbol-level reference model.
// Honours LVDS_TX_IDLE_FILL_EN the same way the design does.
module tb_lvds_8b10b_transmit;
   localparam int NB = 2;

   logic clk;
   logic reset;
   logic serial_o, busy_o, frame_sent_o;

   lvds_8b10b_transmit_if #(.NUM_BYTES(NB)) bus ();

   lvds_8b10b_transmit #(.NUM_BYTES(NB)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .serial_o     (serial_o),
      .busy_o       (busy_o),
      .frame_sent_o (frame_sent_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // RD- sub-block tables: 6b as abcdei (a = MSB), 4b as fghj (f = MSB)
   localparam logic [5:0] T6 [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   localparam logic [3:0] T4 [8] = '{
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

   function automatic logic [9:0] wire_of(input logic [9:0] abcdeifghj);
      logic [9:0] w;
      for (int i = 0; i < 10; i++) w[i] = abcdeifghj[9-i];
      return w;
   endfunction

   // returns {rd_after, wire-order code}
   function automatic logic [10:0] ref_enc(input logic [7:0] d, input logic rd);
      logic [5:0] s6;
      logic [3:0] s4;
      logic       r;
      int         x, y;
      x  = int'(d[4:0]);
      y  = int'(d[7:5]);
      s6 = T6[x];
      if (rd && ($countones(s6) != 3 || x == 7)) s6 = ~s6;
      r  = rd ^ ($countones(s6) != 3);
      s4 = T4[y];
      if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) || (r && (x == 11 || x == 13 || x == 14))))
         s4 = 4'b0111;
      if (r && ($countones(s4) != 2 || y == 3)) s4 = ~s4;
      r  = r ^ ($countones(s4) != 2);
      return {r, wire_of({s6, s4})};
   endfunction

   logic [9:0] K_N, K_P, D215;
   initial begin
      K_N  = wire_of(10'b0011111001);
      K_P  = wire_of(10'b1100000110);
      D215 = wire_of(10'b1010101010);
   end

   // reference model state
   int               m_pos;
   int               m_sent;
   int               m_accepted;
   logic             m_pending, m_in_frame, m_rd, m_fs, m_cur_frame;
   logic [8*NB-1:0]  m_hold;
   logic [9:0]       m_cur, m_cap;
   logic             m_rec;
   logic [9:0]       q_sym[$];
   int               cnt_fs;

   task automatic model_reset();
      m_pos = 0; m_sent = 0;
      m_pending = 1'b0; m_in_frame = 1'b0; m_rd = 1'b0; m_fs = 1'b0; m_cur_frame = 1'b0;
      m_hold = '0; m_cur = '0; m_cap = '0;
   endtask

   // m_pos counts cycles since reset; a new symbol starts every 10th edge
   task automatic model_edge();
      logic       hs, clr;
      logic [10:0] e;
      hs = bus.data_valid_i && !m_pending;
      clr = 1'b0;
      m_fs = 1'b0;
      m_pos++;
      if (m_pos % 10 == 0) begin
         m_cap = '0;
         if (m_in_frame) begin
            e = ref_enc(m_hold[8*m_sent +: 8], m_rd);
            m_cur = e[9:0]; m_rd = e[10]; m_cur_frame = 1'b1;
            m_sent++;
            if (m_sent == NB) begin m_in_frame = 1'b0; clr = 1'b1; m_fs = 1'b1; end
         end else if (m_pending) begin
            m_cur = m_rd ? K_P : K_N;
            m_rd = ~m_rd; m_in_frame = 1'b1; m_sent = 0; m_cur_frame = 1'b1;
         end else begin
            m_cur_frame = 1'b0;
`ifdef LVDS_TX_IDLE_FILL_EN
            m_cur = D215;
`else
            m_cur = '0;
`endif
         end
      end
      if (hs) begin m_pending = 1'b1; m_hold = bus.data_i; m_accepted++; end
      else if (clr) m_pending = 1'b0;
   endtask

   task automatic model_sample();
      int bp;
      bp = m_pos % 10;
      m_cap[bp] = serial_o;
      if (bp == 9) begin
         check_val("symbol", {22'd0, m_cap}, {22'd0, m_cur});
         if (m_rec && m_cur_frame) q_sym.push_back(m_cap);
      end
      check_val("rdy_busy_fs", {29'd0, bus.ready_o, busy_o, frame_sent_o},
                {29'd0, !m_pending, m_cur_frame, m_fs});
      cnt_fs += int'(frame_sent_o);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_sample();
   endtask

   initial begin
      logic found;
      reset = 1'b1;
      bus.data_valid_i = 1'b0;
      bus.data_i = '0;
      m_rec = 1'b0; m_accepted = 0; cnt_fs = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check_val("reset_outs", {28'd0, serial_o, bus.ready_o, busy_o, frame_sent_o}, 32'h4);
      reset = 1'b0;
      model_reset();

      // single frame 0x1234
      m_rec = 1'b1; q_sym.delete(); cnt_fs = 0;
      bus.data_i = 16'h1234; bus.data_valid_i = 1'b1;
      tick();
      bus.data_valid_i = 1'b0;
      for (int i = 0; i < 45; i++) begin bus.data_i = 16'($urandom); tick(); end
      check_val("p1_nsym", q_sym.size(), 3);
      check_val("p1_comma", {22'd0, q_sym[0]}, {22'd0, K_N});
      check_val("p1_byte0", {22'd0, q_sym[1]}, {22'd0, wire_of(10'b0010111001)});
      check_val("p1_byte1", {22'd0, q_sym[2]}, {22'd0, wire_of(10'b0100110100)});
      check_val("p1_fs_cnt", cnt_fs, 1);

      // back-to-back; 0x3434 leaves RD+ so the next comma must be the RD+ form
      q_sym.delete();
      bus.data_i = 16'h3434; bus.data_valid_i = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) begin bus.data_i = 16'($urandom); tick(); end
      check_val("b2b_comma1", {22'd0, q_sym[0]}, {22'd0, K_N});
      check_val("b2b_comma2_rdp", {22'd0, q_sym[3]}, {22'd0, K_P});
      bus.data_valid_i = 1'b0;
      for (int i = 0; i < 40; i++) tick();

      // 1000 random payloads with random valid gaps and data churn while busy
      m_rec = 1'b0;
      m_accepted = 0;
      for (int i = 0; i < 60000 && m_accepted < 1000; i++) begin
         bus.data_valid_i = ($urandom_range(3) != 0);
         bus.data_i = 16'($urandom);
         tick();
      end
      check_val("rand_frames", m_accepted, 1000);

      // idle line
      bus.data_valid_i = 1'b0;
      for (int i = 0; i < 80; i++) tick();

      // reset during the second data symbol
      bus.data_i = 16'($urandom); bus.data_valid_i = 1'b1;
      tick();
      bus.data_valid_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         found = m_cur_frame && (m_sent == 2) && (m_pos % 10 == 4);
      end
      check_val("rst_reach", {31'd0, found}, 32'd1);
      #2 reset = 1'b1;
      #1 check_val("rst_mid_outs", {28'd0, serial_o, bus.ready_o, busy_o, frame_sent_o}, 32'h4);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      m_rec = 1'b1; q_sym.delete();
      bus.data_i = 16'($urandom); bus.data_valid_i = 1'b1;
      tick();
      bus.data_valid_i = 1'b0;
      for (int i = 0; i < 45; i++) tick();
      check_val("post_rst_comma", {22'd0, q_sym[0]}, {22'd0, K_N});
      check_val("post_rst_nsym", q_sym.size(), 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
